tile_scheduler: RTL and testbench

- Sequences one super-matrix multiply (SUPER_A_ROWS x SUPER_W_ROWS activations times SUPER_W_ROWS x SUPER_W_COLS weights) on the SYS_ROWS x SYS_COLS systolic array.
- Tile by tile, it:
  - generates weight-buffer reads and the array weight-load strobe;
  - streams the matching activation column block;
  - issues delayed accumulator writes, overwriting on the first row-tile of each output column block and accumulating afterwards.
- Sits between the instruction decoder (start/done) and the weight buffer, input buffer and accumulator.

---
 rtl/tile_scheduler_pkg.sv | 45 ++++
 rtl/sched_delay_line.sv | 32 +++
 rtl/tile_scheduler.sv | 164 ++++++++++++++++
 tb/tb_tile_scheduler.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/tile_scheduler_pkg.sv
// Shared configuration for the tile scheduler: array/super-matrix geometry,
// derived tile counts, address/counter widths and the FSM state type.
package tile_scheduler_pkg;

    localparam int SYS_ROWS     = 2;
    localparam int SYS_COLS     = 2;
    localparam int SUPER_W_ROWS = 8;
    localparam int SUPER_W_COLS = 8;
    localparam int SUPER_A_ROWS = 12;

    localparam int TR        = SUPER_W_ROWS / SYS_ROWS;
    localparam int TC        = SUPER_W_COLS / SYS_COLS;
    localparam int NUM_TILES = TR * TC;
    localparam int PIPE_LAT  = 1 + SYS_ROWS + SYS_COLS - 1;

    // $clog2 yields 0 for a depth of 1; a zero-width vector is not legal.
    function automatic int clog2_min1(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

    localparam int W_ADDR_W   = clog2_min1(NUM_TILES * SYS_ROWS);
    localparam int A_ADDR_W   = clog2_min1(TR * SUPER_A_ROWS);
    localparam int ACC_ADDR_W = clog2_min1(TC * SUPER_A_ROWS);

    localparam int K_W  = clog2_min1(SYS_ROWS);
    localparam int I_W  = clog2_min1(SUPER_A_ROWS);
    localparam int D_W  = clog2_min1(PIPE_LAT);
    localparam int TR_W = clog2_min1(TR);
    localparam int TC_W = clog2_min1(TC);

    localparam logic [K_W-1:0]  K_LAST  = K_W'(SYS_ROWS - 1);
    localparam logic [I_W-1:0]  I_LAST  = I_W'(SUPER_A_ROWS - 1);
    localparam logic [D_W-1:0]  D_LAST  = D_W'(PIPE_LAT - 1);
    localparam logic [TR_W-1:0] TR_LAST = TR_W'(TR - 1);
    localparam logic [TC_W-1:0] TC_LAST = TC_W'(TC - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD_W   = 3'd1,
        ST_STREAM_A = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_FINISH   = 3'd4
    } tile_sched_state_e;

endpackage

// File: rtl/sched_delay_line.sv
// WIDTH x DEPTH shift register with synchronous clear and a shift enable;
// carries the accumulator-write request alongside the array pipeline.
module sched_delay_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    // Clear wins over enable so an abort also drops in-flight writes.
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            for (int s = 0; s < DEPTH; s++) begin
                stage_q[s] <= '0;
            end
        end else if (en_i) begin
            stage_q[0] <= d_i;
            for (int s = 1; s < DEPTH; s++) begin
                stage_q[s] <= stage_q[s-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/tile_scheduler.sv
// Tile scheduler: walks the weight super-matrix tile by tile (column-major, tr
// innermost), issuing weight loads, activation streams and delayed acc writes.
module tile_scheduler
    import tile_scheduler_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  hold_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  w_rd_en_o,
    output logic [W_ADDR_W-1:0]   w_rd_addr_o,
    output logic                  w_load_o,
    output logic                  a_rd_en_o,
    output logic [A_ADDR_W-1:0]   a_rd_addr_o,
    output logic                  acc_wr_en_o,
    output logic [ACC_ADDR_W-1:0] acc_wr_addr_o,
    output logic                  acc_accumulate_o
);

    localparam int DL_W = ACC_ADDR_W + 2;

    if ((SUPER_W_ROWS % SYS_ROWS) != 0) begin : g_chk_rows
        $error("SUPER_W_ROWS must be a multiple of SYS_ROWS");
    end
    if ((SUPER_W_COLS % SYS_COLS) != 0) begin : g_chk_cols
        $error("SUPER_W_COLS must be a multiple of SYS_COLS");
    end

    tile_sched_state_e state_q, state_d;
    logic [K_W-1:0]    k_q, k_d;
    logic [I_W-1:0]    i_q, i_d;
    logic [D_W-1:0]    dr_q, dr_d;
    logic [TR_W-1:0]   tr_q, tr_d;
    logic [TC_W-1:0]   tc_q, tc_d;
    logic              w_load_q;
    logic              advance_s;
    logic              w_rd_en_s;
    logic              a_rd_en_s;
    logic [DL_W-1:0]   dl_in_s;
    logic [DL_W-1:0]   dl_out_s;

    // hold freezes everything except IDLE, where start must still be taken.
    assign advance_s = ~hold_i | (state_q == ST_IDLE);

    // State and counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            k_q      <= '0;
            i_q      <= '0;
            dr_q     <= '0;
            tr_q     <= '0;
            tc_q     <= '0;
            w_load_q <= 1'b0;
        end else if (advance_s) begin
            state_q  <= state_d;
            k_q      <= k_d;
            i_q      <= i_d;
            dr_q     <= dr_d;
            tr_q     <= tr_d;
            tc_q     <= tc_d;
            w_load_q <= w_rd_en_s;
        end
    end

    // Next-state, counter advance and raw read enables.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        i_d       = i_q;
        dr_d      = dr_q;
        tr_d      = tr_q;
        tc_d      = tc_q;
        w_rd_en_s = 1'b0;
        a_rd_en_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_LOAD_W;
                    k_d     = '0;
                    i_d     = '0;
                    dr_d    = '0;
                    tr_d    = '0;
                    tc_d    = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD_W: begin
                w_rd_en_s = 1'b1;
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    state_d = ST_STREAM_A;
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end
            ST_STREAM_A: begin
                a_rd_en_s = 1'b1;
                if (i_q == I_LAST) begin
                    i_d     = '0;
                    state_d = ST_DRAIN;
                end else begin
                    i_d = i_q + I_W'(1);
                end
            end
            ST_DRAIN: begin
                if (dr_q != D_LAST) begin
                    dr_d = dr_q + D_W'(1);
                end else if (tr_q != TR_LAST) begin
                    dr_d    = '0;
                    tr_d    = tr_q + TR_W'(1);
                    state_d = ST_LOAD_W;
                end else if (tc_q != TC_LAST) begin
                    dr_d    = '0;
                    tr_d    = '0;
                    tc_d    = tc_q + TC_W'(1);
                    state_d = ST_LOAD_W;
                end else begin
                    dr_d    = '0;
                    tr_d    = '0;
                    tc_d    = '0;
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Request entering the pipeline: {write enable, acc address, accumulate}.
    assign dl_in_s = {a_rd_en_s,
                      ACC_ADDR_W'(int'(tc_q) * SUPER_A_ROWS + int'(i_q)),
                      (tr_q != '0)};

    sched_delay_line #(
        .WIDTH (DL_W),
        .DEPTH (PIPE_LAT)
    ) u_delay_line (
        .clk_i (clk_i),
        .clr_i (rst_i),
        .en_i  (~hold_i),
        .d_i   (dl_in_s),
        .q_o   (dl_out_s)
    );

    assign busy_o           = (state_q != ST_IDLE);
    assign done_o           = (state_q == ST_FINISH) & ~hold_i;
    assign w_rd_en_o        = w_rd_en_s & ~hold_i;
    assign w_rd_addr_o      = W_ADDR_W'((int'(tc_q) * TR + int'(tr_q)) * SYS_ROWS + int'(k_q));
    assign w_load_o         = w_load_q & ~hold_i;
    assign a_rd_en_o        = a_rd_en_s & ~hold_i;
    assign a_rd_addr_o      = A_ADDR_W'(int'(tr_q) * SUPER_A_ROWS + int'(i_q));
    assign acc_wr_en_o      = dl_out_s[DL_W-1] & ~hold_i;
    assign acc_wr_addr_o    = dl_out_s[DL_W-2:1];
    assign acc_accumulate_o = dl_out_s[0];

endmodule

// File: tb/tb_tile_scheduler.sv
// Directed bench for tile_scheduler: expected reads/writes are queued per run
// and popped as the scheduler issues them; timing landmarks checked afterwards.
module tb_tile_scheduler;

    logic       clk = 1'b0;
    logic       rst, start, hold;
    logic       busy, done, w_rd_en, w_load, a_rd_en, acc_wr_en, acc_accumulate;
    logic [4:0] w_rd_addr;
    logic [5:0] a_rd_addr, acc_wr_addr;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int wq[$], aq[$], accq[$];
    int w_cyc[$], wl_cyc[$], a_cyc[$], acc_cyc[$];
    int n_ow = 0, n_done = 0, done_cyc = -1;
    logic [23:0] snap;
    logic [5:0]  s_a_addr;

    always #5 clk = ~clk;

    tile_scheduler dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .start_i          (start),
        .hold_i           (hold),
        .busy_o           (busy),
        .done_o           (done),
        .w_rd_en_o        (w_rd_en),
        .w_rd_addr_o      (w_rd_addr),
        .w_load_o         (w_load),
        .a_rd_en_o        (a_rd_en),
        .a_rd_addr_o      (a_rd_addr),
        .acc_wr_en_o      (acc_wr_en),
        .acc_wr_addr_o    (acc_wr_addr),
        .acc_accumulate_o (acc_accumulate)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_run();
        wq.delete(); aq.delete(); accq.delete();
        w_cyc.delete(); wl_cyc.delete(); a_cyc.delete(); acc_cyc.delete();
        n_ow = 0; n_done = 0; done_cyc = -1;
    endtask

    // Expected transactions of one full run: 4x4 tiles, 2 weight rows, 12 activation rows.
    task automatic push_run();
        for (int tc = 0; tc < 4; tc++) begin
            for (int tr = 0; tr < 4; tr++) begin
                for (int k = 0; k < 2; k++) wq.push_back((tc * 4 + tr) * 2 + k);
                for (int i = 0; i < 12; i++) begin
                    aq.push_back(tr * 12 + i);
                    accq.push_back((tc * 12 + i) * 2 + ((tr != 0) ? 1 : 0));
                end
            end
        end
    endtask

    task automatic monitor();
        int e;
        snap = {busy, done, w_rd_en, w_rd_addr, w_load, a_rd_en, a_rd_addr,
                acc_wr_en, acc_wr_addr, acc_accumulate};
        s_a_addr = a_rd_addr;
        if (hold === 1'b1) chk("hold_enables", 64'({w_rd_en, w_load, a_rd_en, acc_wr_en}), 64'd0);
        if (w_rd_en === 1'b1) begin
            w_cyc.push_back(cyc);
            chk("w_pending", 64'(wq.size() > 0), 64'd1);
            if (wq.size() > 0) begin
                e = wq.pop_front();
                chk("w_rd_addr", 64'(w_rd_addr), 64'(e));
            end
        end
        if (w_load === 1'b1) wl_cyc.push_back(cyc);
        if (a_rd_en === 1'b1) begin
            a_cyc.push_back(cyc);
            chk("a_pending", 64'(aq.size() > 0), 64'd1);
            if (aq.size() > 0) begin
                e = aq.pop_front();
                chk("a_rd_addr", 64'(a_rd_addr), 64'(e));
            end
        end
        if (acc_wr_en === 1'b1) begin
            acc_cyc.push_back(cyc);
            if (acc_accumulate === 1'b0) n_ow++;
            chk("acc_pending", 64'(accq.size() > 0), 64'd1);
            if (accq.size() > 0) begin
                e = accq.pop_front();
                chk("acc_wr_addr", 64'(acc_wr_addr), 64'(e / 2));
                chk("acc_accumulate", 64'(acc_accumulate), 64'(e % 2));
            end
        end
        if (done === 1'b1) begin
            n_done++;
            done_cyc = cyc;
        end
    endtask

    // Inputs set before the call apply to cycle 'cyc'; outputs sampled mid-cycle.
    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_totals(input string run);
        chk({run, "_acc_writes"}, 64'(acc_cyc.size()), 64'd192);
        chk({run, "_overwrites"}, 64'(n_ow), 64'd48);
        chk({run, "_w_reads"}, 64'(w_cyc.size()), 64'd32);
        chk({run, "_w_loads"}, 64'(wl_cyc.size()), 64'd32);
        chk({run, "_a_reads"}, 64'(a_cyc.size()), 64'd192);
        chk({run, "_left_over"}, 64'(wq.size() + aq.size() + accq.size()), 64'd0);
        chk({run, "_done_pulses"}, 64'(n_done), 64'd1);
        chk({run, "_idle_after"}, 64'(snap), 64'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; hold = 1'b0;
        clear_run();

        // Reset, then idle.
        repeat (3) tick();
        rst = 1'b0;
        chk("reset_outputs", 64'(snap), 64'd0);
        repeat (20) tick();
        chk("idle_outputs", 64'(snap), 64'd0);
        chk("idle_no_activity", 64'(w_cyc.size() + a_cyc.size() + acc_cyc.size() + n_done), 64'd0);

        // Full run without hold.
        clear_run(); push_run();
        cyc = 0; start = 1'b1; tick(); start = 1'b0;
        chk("busy_cycle0", 64'(snap[23]), 64'd0);
        while (n_done == 0 && cyc < 400) begin
            tick();
            if (cyc == 2) chk("busy_cycle1", 64'(snap[23]), 64'd1);
        end
        repeat (5) tick();
        chk("a_done_cycle", 64'(done_cyc), 64'd289);
        chk("a_first_w", 64'(w_cyc[0]), 64'd1);
        chk("a_second_w", 64'(w_cyc[1]), 64'd2);
        chk("a_tile1_w", 64'(w_cyc[2]), 64'd19);
        chk("a_first_wload", 64'(wl_cyc[0]), 64'd2);
        chk("a_first_a", 64'(a_cyc[0]), 64'd3);
        chk("a_last_a_tile0", 64'(a_cyc[11]), 64'd14);
        chk("a_first_acc", 64'(acc_cyc[0]), 64'd7);
        chk("a_last_acc_tile0", 64'(acc_cyc[11]), 64'd18);
        chk("a_last_acc", 64'(acc_cyc[191]), 64'd288);
        check_totals("a");

        // Run with hold in IDLE alongside start, and a 3-cycle hold at i=5 of tile 0.
        clear_run(); push_run();
        cyc = 0; start = 1'b1; hold = 1'b1; tick(); start = 1'b0; hold = 1'b0;
        while (n_done == 0 && cyc < 400) begin
            hold = (cyc >= 8 && cyc <= 10);
            tick();
            if (cyc == 9) chk("b_held_a_addr", 64'(s_a_addr), 64'd5);
        end
        hold = 1'b0;
        repeat (5) tick();
        chk("b_done_cycle", 64'(done_cyc), 64'd292);
        chk("b_first_w", 64'(w_cyc[0]), 64'd1);
        chk("b_a_before_hold", 64'(a_cyc[4]), 64'd7);
        chk("b_a_resume", 64'(a_cyc[5]), 64'd11);
        chk("b_acc_resume", 64'(acc_cyc[1]), 64'd11);
        check_totals("b");

        // Abort by reset at cycle 50, restart at cycle 60 with starts while busy.
        clear_run(); push_run();
        cyc = 0; start = 1'b1; tick(); start = 1'b0;
        while (cyc < 50) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        clear_run();
        tick();
        chk("d_post_reset_outputs", 64'(snap), 64'd0);
        while (cyc < 60) tick();
        chk("d_no_stale_activity", 64'(w_cyc.size() + a_cyc.size() + acc_cyc.size()), 64'd0);
        push_run();
        start = 1'b1; tick(); start = 1'b0;
        while (n_done == 0 && cyc < 700) begin
            start = (cyc == 100 || cyc == 200);
            tick();
        end
        start = 1'b0;
        repeat (5) tick();
        chk("d_done_cycle", 64'(done_cyc), 64'd349);
        chk("d_first_w", 64'(w_cyc[0]), 64'd61);
        chk("d_first_acc", 64'(acc_cyc[0]), 64'd67);
        check_totals("d");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
